rv_emu_retire_cmp: RTL

RV_EMU_RETIRE_CMP -- requirements
Module: rv_emu_retire_cmp

---
 rtl/rv_emu_retire_cmp.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/rv_emu_retire_cmp.sv
// Lock-step retire comparator: buffers expected retire records from an emulation
// model and compares them field-by-field against the CPU's retire stream.
module rv_emu_retire_cmp #(
    parameter int DEPTH        = 4,
    parameter int TIMEOUT      = 1024,
    parameter bit STOP_ON_FAIL = 1'b1
) (
    input  logic         clk_in,
    input  logic         reset_in,
    input  logic         emu_valid,
    output logic         emu_ready,
    input  logic [109:0] emu_rec,
    input  logic [14:0]  emu_checks,
    input  logic         cpu_valid,
    output logic         cpu_ready,
    input  logic [109:0] cpu_rec,
    output logic         mis_valid,
    output logic [14:0]  mis_mask,
    output logic [31:0]  mis_pc,
    output logic         fail,
    output logic         timeout,
    output logic [31:0]  retired_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    // CHECKS bit positions, MSB-first order of emu_checks
    localparam int CHK_PC       = 14;
    localparam int CHK_GPR_WR   = 9;
    localparam int CHK_GPR_ADDR = 8;
    localparam int CHK_GPR_DATA = 7;
    localparam int CHK_CSR_WR   = 6;
    localparam int CHK_CSR_DATA = 5;
    localparam int CHK_EXC      = 2;
    localparam int CHK_MODE     = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic        gpr_wr;
        logic [4:0]  gpr_addr;
        logic [31:0] gpr_data;
        logic        csr_wr;
        logic [31:0] csr_wr_data;
        logic        exc;
        logic [3:0]  cause;
        logic [1:0]  mode;
    } retire_rec_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    logic [109:0] rec_mem [DEPTH];
    logic [14:0]  chk_mem [DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          mis_valid_q, mis_valid_d;
    logic [14:0]   mis_mask_q, mis_mask_d;
    logic [31:0]   mis_pc_q, mis_pc_d;
    logic          fail_q, fail_d;
    logic          timeout_q, timeout_d;
    logic [31:0]   retired_q, retired_d;

    logic          full, empty, push, pop, to_hit;
    retire_rec_t   exp_rec, act_rec;
    logic [14:0]   chk_head, field_diff, mask_c;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign emu_ready = !full && (state_q != ST_FAIL);
    assign cpu_ready = (state_q == ST_RUN) && !empty;
    assign push      = emu_valid && emu_ready;
    assign pop       = cpu_valid && cpu_ready;

    assign exp_rec  = retire_rec_t'(rec_mem[rd_ptr_q]);
    assign act_rec  = retire_rec_t'(cpu_rec);
    assign chk_head = chk_mem[rd_ptr_q];

    // Fields without a comparable counterpart (register reads, events) stay 0 here.
    always_comb begin
        field_diff               = '0;
        field_diff[CHK_PC]       = (exp_rec.pc != act_rec.pc);
        field_diff[CHK_GPR_WR]   = (exp_rec.gpr_wr != act_rec.gpr_wr);
        field_diff[CHK_GPR_ADDR] = exp_rec.gpr_wr && (exp_rec.gpr_addr != act_rec.gpr_addr);
        field_diff[CHK_GPR_DATA] = exp_rec.gpr_wr && (exp_rec.gpr_data != act_rec.gpr_data);
        field_diff[CHK_CSR_WR]   = (exp_rec.csr_wr != act_rec.csr_wr);
        field_diff[CHK_CSR_DATA] = exp_rec.csr_wr && (exp_rec.csr_wr_data != act_rec.csr_wr_data);
        field_diff[CHK_EXC]      = (exp_rec.exc != act_rec.exc) ||
                                   (exp_rec.exc && (exp_rec.cause != act_rec.cause));
        field_diff[CHK_MODE]     = (exp_rec.mode != act_rec.mode);
        mask_c                   = chk_head & field_diff;
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        to_cnt_d    = to_cnt_q;
        mis_mask_d  = mis_mask_q;
        mis_pc_d    = mis_pc_q;
        retired_d   = retired_q;
        to_hit      = 1'b0;
        mis_valid_d = pop && (mask_c != '0);
        fail_d      = fail_q || mis_valid_d;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            retired_d  = retired_q + 32'd1;
            mis_mask_d = mask_c;
            mis_pc_d   = exp_rec.pc;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (pop || empty) begin
            to_cnt_d = '0;
        end else if (state_q == ST_RUN && to_cnt_q != TW'(TIMEOUT)) begin
            to_cnt_d = to_cnt_q + 1'b1;
            to_hit   = (to_cnt_d == TW'(TIMEOUT));
        end
        timeout_d = timeout_q || to_hit;

        case (state_q)
            ST_IDLE: if (push) state_d = ST_RUN;
            ST_RUN:  if (to_hit || (mis_valid_d && STOP_ON_FAIL)) state_d = ST_FAIL;
            default: state_d = ST_FAIL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            to_cnt_q    <= '0;
            mis_valid_q <= 1'b0;
            mis_mask_q  <= '0;
            mis_pc_q    <= '0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            to_cnt_q    <= to_cnt_d;
            mis_valid_q <= mis_valid_d;
            mis_mask_q  <= mis_mask_d;
            mis_pc_q    <= mis_pc_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
            retired_q   <= retired_d;
        end
    end

    // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk_in) begin
        if (push) begin
            rec_mem[wr_ptr_q] <= emu_rec;
            chk_mem[wr_ptr_q] <= emu_checks;
        end
    end

    assign mis_valid   = mis_valid_q;
    assign mis_mask    = mis_mask_q;
    assign mis_pc      = mis_pc_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign retired_cnt = retired_q;

endmodule
